// File: rtl/seq_pkg.sv
// seq_pkg: shared state type, default pattern and width helper for the sequence detector
package seq_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int DEF_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1001;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: history shift register with fill tracking and masked pattern compare
module seq_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               valid,
  input  logic               in,
  input  logic               run,
  input  logic               ovl,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);
  logic [MAX_LEN-1:0] hist, hist_next, mask;
  logic [LEN_W-1:0] fill, fill_next;
  always_comb begin
    hist_next = {hist[MAX_LEN-2:0], in};
    fill_next = fill == LEN_W'(MAX_LEN) ? fill : fill + 1'b1;
    mask = ~({MAX_LEN{1'b1}} << len);
    hit = run && valid && fill_next >= len && (hist_next & mask) == (pattern & mask);
  end
  // non-overlapping mode restarts the fill so the completing bit is not reused
  always_ff @(posedge clk)
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (valid) begin
      hist <= hist_next;
      fill <= hit && !ovl ? '0 : fill_next;
    end
endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector with saturating match counter
module seq_detect_prog import seq_pkg::*; #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int RST_LEN = DEF_LEN,
  parameter logic RST_OVL = 1'b1,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);
  state_t state;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic ovl, hit, len_ok;
  assign len_ok = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
  // a load on the same beat as a data bit wins: the bit never reaches the history
  seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
    .clk(clk),
    .rst(rst),
    .clr(cfg_load),
    .valid(in_valid && !cfg_load),
    .in(in),
    .run(state == RUN),
    .ovl(ovl),
    .pattern(pattern),
    .len(len),
    .hit(hit)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      pattern <= RST_PATTERN;
      len <= LEN_W'(RST_LEN);
      ovl <= RST_OVL;
      cfg_err <= 1'b0;
      out <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (cfg_load) begin
        state <= len_ok ? RUN : IDLE;
        cfg_err <= !len_ok;
        pattern <= cfg_pattern;
        len <= cfg_len;
        ovl <= cfg_ovl;
      end
      out <= hit;
      match_cnt <= cnt_clr ? '0 : hit && match_cnt != '1 ? match_cnt + 1'b1 : match_cnt;
    end
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: table-driven scoreboard bench for the programmable sequence detector
module tb_seq_detect_prog;
  logic clk = 1'b0, rst = 1'b1, in = 1'b0, in_valid = 1'b0, cfg_load = 1'b0, cfg_ovl = 1'b0, cnt_clr = 1'b0;
  logic [7:0] cfg_pattern = 8'hA5;
  logic [3:0] cfg_len = 4'd0;
  logic out, cfg_err, out2, cfg_err2;
  logic [15:0] match_cnt;
  logic [1:0] match_cnt2;
  int errors = 0, checks = 0;
  logic exp_q[$];

  typedef struct {
    logic ld; logic [7:0] pat; logic [3:0] len; logic ovl;
    int n; logic [15:0] bits; logic [15:0] vld; logic [15:0] exp; int cnt; logic err;
  } vec_t;
  vec_t vt[5];

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .out(out), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .out(out2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock: drive at negedge, DUT samples at posedge, out checked at the following negedge
  task automatic cyc(input logic b, input logic v, input logic ld, input logic cc, input logic r, input logic e);
    logic x;
    in = b; in_valid = v; cfg_load = ld; cnt_clr = cc; rst = r;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    x = exp_q.pop_front();
    chk("out", 32'(out), 32'(x));
    chk("out2", 32'(out2), 32'(x));
    in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
    cfg_len = 4'd0; cfg_pattern = 8'hA5;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_ovl = o;
    cyc('0, '0, '1, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b0, 8'h00, 4'd0, 1'b0, 7, 16'b1001001, 16'b1111111, 16'b0001001, 2, 1'b0};
    vt[1] = '{1'b1, 8'b00001001, 4'd4, 1'b0, 7, 16'b1001001, 16'b1111111, 16'b0001000, 1, 1'b0};
    vt[2] = '{1'b1, 8'b10110111, 4'd8, 1'b1, 12, 16'b100111010111, 16'b110110110110, 16'b000000000010, 1, 1'b0};
    vt[3] = '{1'b1, 8'b00001001, 4'd0, 1'b1, 7, 16'b1001001, 16'b1111111, 16'b0000000, 0, 1'b1};
    vt[4] = '{1'b1, 8'b00000101, 4'd3, 1'b1, 5, 16'b10101, 16'b11111, 16'b00101, 2, 1'b0};
    for (int k = 0; k < 5; k++) begin
      if (vt[k].ld) load(vt[k].pat, vt[k].len, vt[k].ovl);
      else begin
        cyc('0, '0, '0, '0, '1, '0);
        chk("reset cnt", 32'(match_cnt), 0);
      end
      chk($sformatf("v%0d cfg_err", k), 32'(cfg_err), 32'(vt[k].err));
      chk($sformatf("v%0d cfg_err2", k), 32'(cfg_err2), 32'(vt[k].err));
      cyc('0, '0, '0, '1, '0, '0);
      for (int i = 0; i < vt[k].n; i++)
        cyc(vt[k].bits[vt[k].n-1-i], vt[k].vld[vt[k].n-1-i], '0, '0, '0, vt[k].exp[vt[k].n-1-i]);
      chk($sformatf("v%0d cnt", k), 32'(match_cnt), 32'(vt[k].cnt));
      chk($sformatf("v%0d cnt2", k), 32'(match_cnt2), 32'(vt[k].cnt > 3 ? 3 : vt[k].cnt));
    end
    // saturation on the narrow counter, then clear coinciding with a match
    load(8'b00000001, 4'd1, 1'b1);
    cyc('0, '0, '0, '1, '0, '0);
    repeat (6) cyc('1, '1, '0, '0, '0, '1);
    chk("sat cnt16", 32'(match_cnt), 6);
    chk("sat cnt2", 32'(match_cnt2), 3);
    cyc('1, '1, '0, '1, '0, '1);
    chk("clr+match cnt", 32'(match_cnt), 0);
    chk("clr+match cnt2", 32'(match_cnt2), 0);
    // reset mid-pattern discards the partial history
    cyc('0, '0, '0, '0, '1, '0);
    cyc('1, '1, '0, '0, '0, '0);
    cyc('0, '1, '0, '0, '0, '0);
    cyc('0, '1, '0, '0, '0, '0);
    cyc('0, '0, '0, '0, '1, '0);
    cyc('1, '1, '0, '0, '0, '0);
    cyc('0, '1, '0, '0, '0, '0);
    cyc('0, '1, '0, '0, '0, '0);
    cyc('1, '1, '0, '0, '0, '1);
    chk("rst mid cnt", 32'(match_cnt), 1);
    // load coinciding with the completing bit discards it
    cyc('0, '1, '0, '0, '0, '0);
    cyc('0, '1, '0, '0, '0, '0);
    cfg_pattern = 8'b00001001; cfg_len = 4'd4; cfg_ovl = 1'b1;
    cyc('1, '1, '1, '0, '0, '0);
    chk("load+bit cnt", 32'(match_cnt), 1);
    cyc('0, '1, '0, '0, '0, '0);
    cyc('0, '1, '0, '0, '0, '0);
    cyc('1, '1, '0, '0, '0, '0);
    cyc('1, '1, '0, '0, '0, '0);
    cyc('0, '1, '0, '0, '0, '0);
    cyc('0, '1, '0, '0, '0, '0);
    cyc('1, '1, '0, '0, '0, '1);
    chk("after load cnt", 32'(match_cnt), 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
